clockedlogic_deser: RTL and testbench

Serial-to-parallel receiver, the far end of the clockedlogic shift-out path. Accepts one bit per cycle under a valid strobe and assembles WIDTH-bit words. Completed words are presented on a valid/ready output port. Framing is resynchronised by an explicit start-of-word marker. Sits between the serial link and the word-level consumer; a formal wrapper checks it with past_valid-style properties.

---
 rtl/clockedlogic_deser_if.sv | 30 +++
 rtl/clockedlogic_deser.sv | 115 +++++++++++
 tb/tb_clockedlogic_deser.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clockedlogic_deser_if.sv
// Serial-in / word-out bundle for the clockedlogic deserialiser.
// The slave modport is the deserialiser's view; the master modport is the link-and-consumer side.
interface clockedlogic_deser_if #(
  parameter int unsigned WIDTH = 64
);
  logic             s_valid;
  logic             s_bit;
  logic             s_start;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output s_valid,
    output s_bit,
    output s_start,
    output m_ready,
    input  m_data,
    input  m_valid
  );

  modport slave (
    input  s_valid,
    input  s_bit,
    input  s_start,
    input  m_ready,
    output m_data,
    output m_valid
  );
endinterface

// File: rtl/clockedlogic_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a strobed bit stream,
// resynchronised by s_start, and hands them out on a valid/ready port.
module clockedlogic_deser #(
  parameter int unsigned WIDTH     = 64,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CntW     = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  clockedlogic_deser_if.slave  bus,
  output logic [CntW-1:0]      bit_cnt,
  output logic                 overflow,
  output logic                 frame_err
);

  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [0:0] {StHunt, StCollect} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             complete;
  logic [WIDTH-1:0] word;

  // New bit enters at the LSB (MSB-first) or at the MSB (LSB-first).
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], b};
    end else begin
      return {b, v[WIDTH-1:1]};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHunt;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StHunt && bus.s_valid && bus.s_start) begin
      state_d = StCollect;
    end
  end

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
    complete = 1'b0;
    word     = shift_in(shift_q, bus.s_bit);

    if (bus.s_valid) begin
      if (bus.s_start) begin
        // A start marker always restarts framing; only a partial word makes it an error.
        if (state_q == StCollect && cnt_q != '0) begin
          ferr_d = 1'b1;
        end
        shift_d = shift_in('0, bus.s_bit);
        cnt_d   = OneCnt;
      end else if (state_q == StCollect) begin
        if (cnt_q == LastCnt) begin
          complete = 1'b1;
          shift_d  = '0;
          cnt_d    = '0;
        end else begin
          shift_d = word;
          cnt_d   = cnt_q + OneCnt;
        end
      end
    end

    if (complete) begin
      if (!valid_q || bus.m_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && bus.m_ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.m_data  = data_q;
  assign bus.m_valid = valid_q;
  assign bit_cnt     = cnt_q;
  assign overflow    = ovf_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_clockedlogic_deser.sv
// Checks three deserialiser configurations (8/MSB, 8/LSB, 64/MSB) against a bit-list reference model.
module tb_clockedlogic_deser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clockedlogic_deser_if #(.WIDTH(8))  if0 ();
  clockedlogic_deser_if #(.WIDTH(8))  if1 ();
  clockedlogic_deser_if #(.WIDTH(64)) if2 ();

  logic [2:0] bc0, bc1;
  logic [5:0] bc2;
  logic       ov0, ov1, ov2, fe0, fe1, fe2;

  clockedlogic_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .bit_cnt(bc0), .overflow(ov0), .frame_err(fe0)
  );
  clockedlogic_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .bit_cnt(bc1), .overflow(ov1), .frame_err(fe1)
  );
  clockedlogic_deser #(.WIDTH(64), .MSB_FIRST(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .bit_cnt(bc2), .overflow(ov2), .frame_err(fe2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: received bits kept as an indexed list, word built by bit position.
  int          wid[3] = '{8, 8, 64};
  bit          msb[3] = '{1'b1, 1'b0, 1'b1};
  bit          hunt_m[3];
  int          n_m[3];
  bit          seen_m[3][64];
  logic [63:0] ed_m[3];
  bit          ev_m[3];
  bit          ovf_m[3];
  bit          fe_m[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit b, input bit st, input bit rdy);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] w;
      bit          comp;
      comp = 1'b0;
      w    = '0;
      if (r) begin
        hunt_m[i] = 1'b1;
        n_m[i]    = 0;
        ed_m[i]   = '0;
        ev_m[i]   = 1'b0;
        ovf_m[i]  = 1'b0;
        fe_m[i]   = 1'b0;
      end else begin
        if (v) begin
          if (st) begin
            if (!hunt_m[i] && n_m[i] != 0) fe_m[i] = 1'b1;
            hunt_m[i]    = 1'b0;
            seen_m[i][0] = b;
            n_m[i]       = 1;
          end else if (!hunt_m[i]) begin
            seen_m[i][n_m[i]] = b;
            n_m[i]++;
            if (n_m[i] == wid[i]) begin
              comp = 1'b1;
              for (int k = 0; k < wid[i]; k++) begin
                if (msb[i]) w[wid[i]-1-k] = seen_m[i][k];
                else        w[k]          = seen_m[i][k];
              end
              n_m[i] = 0;
            end
          end
        end
        if (comp) begin
          if (!ev_m[i] || rdy) begin
            ed_m[i] = w;
            ev_m[i] = 1'b1;
          end else begin
            ovf_m[i] = 1'b1;
          end
        end else if (ev_m[i] && rdy) begin
          ev_m[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_dut(input int i, input logic [63:0] md, input logic mv, input int bc,
                         input logic ov, input logic fe);
    chk($sformatf("d%0d.m_valid", i), 64'(mv), 64'(ev_m[i]));
    chk($sformatf("d%0d.m_data", i), md, ed_m[i]);
    chk($sformatf("d%0d.bit_cnt", i), 64'(bc), 64'(n_m[i]));
    chk($sformatf("d%0d.overflow", i), 64'(ov), 64'(ovf_m[i]));
    chk($sformatf("d%0d.frame_err", i), 64'(fe), 64'(fe_m[i]));
  endtask

  task automatic drive(input bit v, input bit b, input bit st, input bit rdy, input bit r);
    rst         = r;
    if0.s_valid = v; if0.s_bit = b; if0.s_start = st; if0.m_ready = rdy;
    if1.s_valid = v; if1.s_bit = b; if1.s_start = st; if1.m_ready = rdy;
    if2.s_valid = v; if2.s_bit = b; if2.s_start = st; if2.m_ready = rdy;
    @(posedge clk);
    model_edge(r, v, b, st, rdy);
    #1;
    chk_dut(0, 64'(if0.m_data), if0.m_valid, int'(bc0), ov0, fe0);
    chk_dut(1, 64'(if1.m_data), if1.m_valid, int'(bc1), ov1, fe1);
    chk_dut(2, if2.m_data, if2.m_valid, int'(bc2), ov2, fe2);
  endtask

  task automatic send_byte(input logic [7:0] val, input bit with_start, input bit rdy);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, val[7-k], with_start && (k == 0), rdy, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] w64;
    w64 = 64'h0000_0000_0000_AAAA;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_m_valid", 64'(if0.m_valid), 64'd0);
    chk("rst_m_data", if2.m_data, 64'd0);
    chk("rst_bit_cnt", 64'(bc0), 64'd0);

    // Bits before the first start are discarded.
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("hunt_bit_cnt", 64'(bc0), 64'd0);

    send_byte(8'hAA, 1'b1, 1'b1);
    chk("aa_msb_data", 64'(if0.m_data), 64'h00AA);
    chk("aa_msb_valid", 64'(if0.m_valid), 64'd1);
    chk("aa_lsb_data", 64'(if1.m_data), 64'h0055);
    chk("aa_flags", 64'({ov0, fe0, ov1, fe1}), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("aa_consumed", 64'(if0.m_valid), 64'd0);

    // Held word blocks the next one.
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b0, 1'b0);
    chk("ovf_held_data", 64'(if0.m_data), 64'h00AA);
    chk("ovf_flag", 64'(ov0), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_drained", 64'(if0.m_valid), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_no_0f", 64'(if0.m_valid), 64'd0);

    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("partial_cnt", 64'(bc0), 64'd3);
    send_byte(8'hC3, 1'b1, 1'b1);
    chk("ferr_flag", 64'(fe0), 64'd1);
    chk("ferr_word", 64'(if0.m_data), 64'h00C3);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 64; k++) begin
      while ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, w64[63-k], k == 0, 1'b1, 1'b0);
    end
    chk("w64_data", if2.m_data, 64'h0000_0000_0000_AAAA);
    chk("w64_valid", 64'(if2.m_valid), 64'd1);
    chk("w64_cnt", 64'(bc2), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("w64_once", 64'(if2.m_valid), 64'd0);

    send_byte(8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_cnt", 64'(bc0), 64'd5);
    chk("mid_valid", 64'(if0.m_valid), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_valid", 64'(if0.m_valid), 64'd0);
    chk("mid_rst_cnt", 64'(bc0), 64'd0);
    chk("mid_rst_flags", 64'({ov0, fe0}), 64'd0);
    for (int k = 0; k < 10; k++) drive(1'b1, k[0], 1'b0, 1'b1, 1'b0);
    chk("post_rst_hunt_valid", 64'(if0.m_valid), 64'd0);
    chk("post_rst_hunt_cnt", 64'(bc0), 64'd0);

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
            1'($urandom), $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
